// File: rtl/reg_sb_pkg.sv
// Shared types and defaults for the register hazard scoreboard.
// Optional same-cycle writeback release is selected by REG_SB_WB_BYPASS_EN.
package reg_sb_pkg;

  localparam int SB_NUM_REGS   = 32;
  localparam int SB_ADDR_W     = 5;
  localparam int SB_CNT_W      = 2;
  localparam int STALL_CNT_W   = 16;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } sb_state_t;

  // Stall-length counter step, holding at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] stall_cnt_inc(input logic [STALL_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/reg_sb_counter.sv
// Pending-write counter for one architectural register: saturating up/down
// with synchronous clear; reports next-state nonzero and underflow attempts.
module reg_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_nonzero,
  output logic             o_underflow
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_dec_ok;

  // A retire request only counts when there is something outstanding.
  assign w_dec_ok = i_dec && (r_cnt != '0);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && !w_dec_ok) begin
      if (r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
    end else if (w_dec_ok && !i_inc) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_cnt <= '0;
    else       r_cnt <= w_cnt_nxt;
  end

  assign o_cnt       = r_cnt;
  // Next-state view so the parent's busy register matches the updated count.
  assign o_nonzero   = (w_cnt_nxt != '0);
  assign o_underflow = i_dec && (r_cnt == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// Hazard scoreboard and stall controller for the decode-stage register file.
// Define REG_SB_WB_BYPASS_EN to let a same-cycle writeback release a hazard.
module reg_scoreboard
  import reg_sb_pkg::*;
#(
  parameter int NUM_REGS      = SB_NUM_REGS,
  parameter int ADDR_W        = SB_ADDR_W,
  parameter int CNT_W         = SB_CNT_W,
  parameter int STALL_TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic                issue_rs1_used,
  input  logic                issue_rs2_used,
  input  logic [ADDR_W-1:0]   issue_rd,
  input  logic                issue_rd_wr,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic                stall_flag,
  output logic                issue_accept,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                stall_timeout,
  output logic                wb_underflow
);

  localparam logic [CNT_W-1:0]       CNT_MAX = '1;
  localparam logic [STALL_CNT_W-1:0] TO_VAL  = STALL_CNT_W'(STALL_TIMEOUT);

  logic [CNT_W-1:0]       w_cnt  [NUM_REGS];
  logic [CNT_W-1:0]       w_hcnt [NUM_REGS];
  logic [NUM_REGS-1:0]    w_nz_nxt;
  logic [NUM_REGS-1:0]    w_uf;
  logic                   w_hazard;
  logic                   w_rs1_hz;
  logic                   w_rs2_hz;
  logic                   w_rd_hz;

  sb_state_t              r_state;
  sb_state_t              w_state_nxt;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic [STALL_CNT_W-1:0] w_stall_cnt_nxt;
  logic [NUM_REGS-1:0]    r_busy;
  logic                   r_timeout;
  logic                   r_underflow;

  // Register 0 is hardwired: never pending, never underflows.
  assign w_cnt[0]    = '0;
  assign w_nz_nxt[0] = 1'b0;
  assign w_uf[0]     = 1'b0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_cnt
    reg_sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .i_clk      (clk),
      .i_rst      (reset),
      .i_clr      (flush),
      .i_inc      (issue_accept && issue_rd_wr && (issue_rd == ADDR_W'(gi))),
      .i_dec      (wb_valid && (wb_addr == ADDR_W'(gi))),
      .o_cnt      (w_cnt[gi]),
      .o_nonzero  (w_nz_nxt[gi]),
      .o_underflow(w_uf[gi])
    );
  end

  // Counts seen by hazard detection; with bypass, this cycle's retire is applied first.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_hcnt[i] = w_cnt[i];
`ifdef REG_SB_WB_BYPASS_EN
      if (wb_valid && (wb_addr == ADDR_W'(i)) && (w_cnt[i] != '0))
        w_hcnt[i] = w_cnt[i] - 1'b1;
`endif
    end
  end

  assign w_rs1_hz = issue_rs1_used && (issue_rs1 != '0) && (w_hcnt[issue_rs1] != '0);
  assign w_rs2_hz = issue_rs2_used && (issue_rs2 != '0) && (w_hcnt[issue_rs2] != '0);
  assign w_rd_hz  = issue_rd_wr    && (issue_rd  != '0) && (w_hcnt[issue_rd] == CNT_MAX);
  assign w_hazard = w_rs1_hz || w_rs2_hz || w_rd_hz;

  assign stall_flag   = issue_valid &&  w_hazard && !flush && !reset;
  assign issue_accept = issue_valid && !w_hazard && !flush && !reset;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:   if (stall_flag)  w_state_nxt = STALL;
      STALL: if (!stall_flag) w_state_nxt = RUN;
    endcase
    if (reset || flush) w_state_nxt = RUN;
    w_stall_cnt_nxt = (w_state_nxt == STALL) ? stall_cnt_inc(r_stall_cnt) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_stall_cnt <= '0;
      r_busy      <= '0;
      r_timeout   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_busy      <= w_nz_nxt;
      if ((w_state_nxt == STALL) && (w_stall_cnt_nxt >= TO_VAL)) r_timeout <= 1'b1;
      // A writeback swallowed by a flush is not treated as a bookkeeping error.
      if (!flush && (|w_uf)) r_underflow <= 1'b1;
    end
  end

  assign busy_vec      = r_busy;
  assign stall_timeout = r_timeout;
  assign wb_underflow  = r_underflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed hazard scenarios followed
// by a randomized phase, all compared against a behavioural scoreboard.
module tb_reg_scoreboard;

  localparam int NR  = 32;
  localparam int AW  = 5;
  localparam int CW  = 2;
  localparam int TO  = 8;
  localparam int MAXC = (1 << CW) - 1;
`ifdef REG_SB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk;
  logic          reset, flush, issue_valid;
  logic [AW-1:0] issue_rs1, issue_rs2, issue_rd, wb_addr;
  logic          issue_rs1_used, issue_rs2_used, issue_rd_wr, wb_valid;
  logic          stall_flag, issue_accept, stall_timeout, wb_underflow;
  logic [NR-1:0] busy_vec;

  reg_scoreboard #(
    .NUM_REGS(NR), .ADDR_W(AW), .CNT_W(CW), .STALL_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rs1_used(issue_rs1_used), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_wr(issue_rd_wr),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .stall_flag(stall_flag), .issue_accept(issue_accept), .busy_vec(busy_vec),
    .stall_timeout(stall_timeout), .wb_underflow(wb_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          stall;
    logic          acc;
    logic [NR-1:0] busy;
    logic          to;
    logic          uf;
  } exp_t;

  exp_t          sbq[$];
  int            m_cnt[NR];
  bit            m_to, m_uf;
  int            m_scnt;
  int            n_chk, n_fail;
  logic          last_stall, last_to, last_uf;
  logic [NR-1:0] last_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int r);
    int e;
    e = m_cnt[r];
    if (BYP && wb_valid && (int'(wb_addr) == r) && (e != 0)) e--;
    return e;
  endfunction

  function automatic bit m_hazard();
    return (issue_rs1_used && issue_rs1 != 0 && eff(int'(issue_rs1)) != 0) ||
           (issue_rs2_used && issue_rs2 != 0 && eff(int'(issue_rs2)) != 0) ||
           (issue_rd_wr    && issue_rd  != 0 && eff(int'(issue_rd)) == MAXC);
  endfunction

  task automatic step(input bit rst, input bit fl, input bit iv,
                      input int r1, input bit u1, input int r2, input bit u2,
                      input int rd, input bit rdw, input bit wv, input int wa,
                      input string tag);
    exp_t e, got;
    bit   hz;
    int   inc_r, dec_r;
    reset = rst; flush = fl; issue_valid = iv;
    issue_rs1 = AW'(r1); issue_rs1_used = u1;
    issue_rs2 = AW'(r2); issue_rs2_used = u2;
    issue_rd  = AW'(rd); issue_rd_wr = rdw;
    wb_valid  = wv; wb_addr = AW'(wa);
    hz      = m_hazard();
    e.stall = iv && hz && !fl && !rst;
    e.acc   = iv && !hz && !fl && !rst;
    for (int i = 0; i < NR; i++) e.busy[i] = (m_cnt[i] != 0);
    e.to = m_to;
    e.uf = m_uf;
    sbq.push_back(e);
    @(negedge clk);
    got = sbq.pop_front();
    check({tag, ".stall"}, stall_flag,    got.stall);
    check({tag, ".acc"},   issue_accept,  got.acc);
    check({tag, ".busy"},  busy_vec,      got.busy);
    check({tag, ".to"},    stall_timeout, got.to);
    check({tag, ".uf"},    wb_underflow,  got.uf);
    last_stall = stall_flag; last_busy = busy_vec;
    last_to = stall_timeout; last_uf = wb_underflow;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      m_to = 0; m_uf = 0; m_scnt = 0;
    end else if (fl) begin
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
      m_scnt = 0;
    end else begin
      if (wv && wa != 0 && m_cnt[wa] == 0) m_uf = 1;
      inc_r = (e.acc && rdw && rd != 0) ? rd : -1;
      dec_r = (wv && wa != 0 && m_cnt[wa] != 0) ? wa : -1;
      if (inc_r != dec_r) begin
        if (inc_r >= 0) m_cnt[inc_r]++;
        if (dec_r >= 0) m_cnt[dec_r]--;
      end
      if (e.stall) begin
        if (m_scnt < 65535) m_scnt++;
        if (m_scnt >= TO) m_to = 1;
      end else begin
        m_scnt = 0;
      end
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    m_to = 0; m_uf = 0; m_scnt = 0;
    for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    reset = 1; flush = 0; issue_valid = 0;
    issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
    issue_rs1_used = 0; issue_rs2_used = 0; issue_rd_wr = 0;
    wb_valid = 0; wb_addr = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset state; outputs forced low while reset is high
    step(1, 0, 1, 5, 1, 0, 0, 5, 1, 0, 0, "rst");

    // RAW on r5, released by writeback
    step(0, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0, "iss5");
    step(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, "raw5");
    check("raw5.stall_d", last_stall, 1);
    check("raw5.busy5_d", last_busy[5], 1);
    step(0, 0, 1, 5, 1, 0, 0, 0, 0, 1, 5, "wb5");
    check("wb5.stall_d", last_stall, BYP ? 0 : 1);
    step(0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0, "rel5");
    check("rel5.stall_d", last_stall, 0);
    check("rel5.busy5_d", last_busy[5], 0);

    // r7 pending count saturation
    for (int k = 0; k < 3; k++) step(0, 0, 1, 0, 0, 0, 0, 7, 1, 0, 0, "iss7");
    step(0, 0, 1, 0, 0, 0, 0, 7, 1, 0, 0, "iss7d");
    check("iss7d.stall_d", last_stall, 1);
    step(0, 0, 1, 0, 0, 0, 0, 7, 1, 1, 7, "iss7wb");
    step(0, 0, 1, 0, 0, 0, 0, 7, 1, 0, 0, "iss7r");
    step(0, 0, 1, 0, 0, 0, 0, 7, 1, 0, 0, "iss7c");
    check("iss7c.stall_d", last_stall, 1);

    // register 0 never tracked
    step(0, 0, 1, 0, 1, 0, 1, 0, 1, 1, 0, "r0");
    check("r0.stall_d", last_stall, 0);
    step(0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 0, "r0b");
    check("r0b.busy0_d", last_busy[0], 0);
    check("r0b.uf_d", last_uf, 0);

    // sticky underflow survives flush
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "fl1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, "uf9");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "uf9b");
    check("uf9b.uf_d", last_uf, 1);
    check("uf9b.busy9_d", last_busy[9], 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "fl2");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "uf9c");
    check("uf9c.uf_d", last_uf, 1);

    // flush while stalled on pending r4/r15
    step(0, 0, 1, 0, 0, 0, 0, 4, 1, 0, 0, "iss4");
    step(0, 0, 1, 0, 0, 0, 0, 15, 1, 0, 0, "iss15");
    step(0, 0, 1, 4, 1, 15, 1, 0, 0, 0, 0, "st4");
    check("st4.stall_d", last_stall, 1);
    step(0, 1, 1, 4, 1, 15, 1, 0, 0, 0, 0, "fl3");
    check("fl3.stall_d", last_stall, 0);
    step(0, 0, 1, 4, 1, 15, 1, 0, 0, 0, 0, "fl3b");
    check("fl3b.stall_d", last_stall, 0);
    check("fl3b.busy_d", last_busy, 0);

    // stall timeout on r3
    step(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, "t3");
    for (int k = 1; k <= 9; k++) begin
      step(0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, "to");
      if (k == 8) check("to.before_d", last_to, 0);
    end
    check("to.after_d", last_to, 1);
    check("to.stall_d", last_stall, 1);

    // simultaneous issue and writeback on r3 keeps count at 1
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, "t3wb");
    step(0, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, "t3i");
    step(0, 0, 1, 0, 0, 0, 0, 3, 1, 1, 3, "t3x");
    step(0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, "t3y");
    check("t3y.stall_d", last_stall, 1);

    // reset in the middle of a stall
    step(1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, "rm");
    check("rm.stall_d", last_stall, 0);
    step(0, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0, "rm2");
    check("rm2.stall_d", last_stall, 0);
    check("rm2.busy_d", last_busy, 0);
    check("rm2.to_d", last_to, 0);

    // randomized traffic on a small register window
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 7),
           $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), $urandom_range(0, 1),
           ($urandom_range(0, 9) < 4), $urandom_range(0, 7), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
